sdram_bist_ctrl: RTL and testbench
==================================

// Module: sdram_bist_ctrl
// PURPOSE
//  Parametrised SDRAM test-traffic controller between debounced user commands, sdram_c and the UART TX.
//  Writes one burst of a selectable pattern and reads it back. Checks every returned beat against the
//  regenerated pattern and counts errors. Buffers the read data and streams it to TX as bytes, MSB byte first.
// PARAMETERS
//  DW          16    SDRAM data width; multiple of 8, 8..64
//  AW          13    SDRAM address width
//  BURST_LEN   512   beats per write/read burst, >=2
//  FIFO_DEPTH  512   read-data buffer depth in DW-bit words, power of 2
//  LFSR_SEED   16'hACE1  LFSR reload value at start of every burst
// PORTS
//  clk          in   1     clock
//  rst_n        in   1     asynchronous active-low reset
//  start_wr     in   1     1-cycle pulse: start write burst
//  start_rd     in   1     1-cycle pulse: start read burst
//  bank_inc     in   1     1-cycle pulse: bank+1, wraps 3->0
//  page_inc     in   1     1-cycle pulse: addr+1, wraps at 2^AW
//  mode         in   2     pattern: 0 count, 1 walking-one, 2 LFSR, 3 5555/AAAA alternate
//  wr_req       out  1     write request to sdram_c
//  wr_ack       in   1     write grant; wdata consumed from next cycle
//  rd_req       out  1     read request to sdram_c
//  rd_ack       in   1     read grant
//  bank         out  2     bank for current/next burst
//  addr         out  AW    start address for current/next burst
//  wdata        out  DW    write data
//  sd_data      in   DW    read data
//  sd_data_vld  in   1     read data valid
//  tx_rdy       in   1     TX ready for a byte
//  tx_data      out  8     byte to TX
//  tx_vld       out  1     tx_data valid, 1 cycle per byte
//  busy         out  1     FSM not IDLE
//  done         out  1     1-cycle pulse at end of each burst
//  err_cnt      out  16    read mismatches, saturates at FFFF, cleared at each start_rd
//  ovf          out  1     sticky: beat dropped because FIFO full; cleared at start_rd
// BEHAVIOUR
//  - Reset: all outputs 0, bank=0, addr=0, FSM IDLE, FIFO empty, LFSR=LFSR_SEED; async reset aborts any burst.
//  - FSM: IDLE -> WR_REQ on start_wr; IDLE -> RD_REQ on start_rd. Both in the same cycle: write wins, read dropped.
//    WR_REQ: wr_req=1 until the wr_ack cycle, then WR_BURST. RD_REQ: rd_req=1 until the rd_ack cycle, then RD_BURST.
//    WR_BURST: BURST_LEN cycles, idx 0..N-1, one per cycle; done pulses on the idx=N-1 cycle; next state IDLE.
//    RD_BURST: count sd_data_vld beats; done pulses on beat N-1; next state IDLE.
//  - start_*, bank_inc, page_inc and mode changes are ignored while busy. mode is latched on leaving IDLE.
//  - wdata is combinational from idx in WR_BURST, 0 otherwise:
//    count = idx mod 2^DW; walking-one = 1<<(idx mod DW); alt = idx even ? 5555.. : AAAA.. (DW wide);
//    LFSR = 16-bit Fibonacci x^16+x^14+x^13+x^11+1, zero-extended or truncated to DW, steps once per beat.
//  - Read check: expected value regenerated per beat with the same idx/LFSR rules (LFSR reseeded at RD_REQ exit).
//    sd_data != expected -> err_cnt+1, saturating. sd_data_vld outside RD_BURST is ignored.
//  - Buffer: each valid RD_BURST beat is pushed to the FIFO. If full, the beat is dropped and ovf set;
//    the error check still runs on that beat.
//  - Serializer: pops one word when idle and FIFO non-empty, then emits DW/8 bytes MSB first.
//    A byte goes out only in a cycle with tx_rdy=1: tx_vld=1 for one cycle, tx_data registered.
//    Latency from FIFO non-empty to the first tx_vld is <=2 cycles with tx_rdy=1.
//    The serializer drains independently of the FSM, so a new burst may start while draining.
// STRUCTURE
//  - Package sdram_bist_pkg: mode encodings, FSM state enum, LFSR taps and polynomial function.
//  - Sub-module sdram_bist_patgen, instanced twice (write, check): inputs mode, idx, step, load;
//    output pattern word. FIFO inferred inline or as a vendor sync FIFO.
// TESTING
//  1 mode=0, start_wr, wr_ack after 3 cycles -> wr_req high 3 cycles; wdata 0..511 on 512 cycles; done at 511; busy 0.
//  2 mode=0, start_rd, rd_ack, 512 beats sd_data=idx, tx_rdy=1 -> err_cnt=0; 1024 bytes 00,00,00,01..01,FF; ovf=0.
//  3 As 2 but beat 7 = 16'hDEAD -> err_cnt=1; 13th-14th bytes DE,AD; the next start_rd clears err_cnt.
//  4 mode=2 write then echo wdata as read data -> err_cnt=0; first wdata=16'hACE1.
//  5 FIFO_DEPTH=16, tx_rdy=0 during read -> 16 words held, ovf=1; tx_rdy=1 -> exactly 32 bytes out.
//  6 bank_inc x5 in IDLE -> bank=1; bank_inc during WR_BURST ignored; rst_n low mid-burst -> all outputs 0, IDLE.

Source files
------------

// File: rtl/sdram_bist_pkg.sv
// Shared types and pattern helpers for the SDRAM test-traffic controller.
package sdram_bist_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_REQ   = 3'd1,
    ST_WR_BURST = 3'd2,
    ST_RD_REQ   = 3'd3,
    ST_RD_BURST = 3'd4
  } state_e;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1, expressed on the right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/sdram_bist_patgen.sv
// Pattern word generator; one copy drives write data, another regenerates the read reference.
module sdram_bist_patgen
  import sdram_bist_pkg::*;
#(
  parameter int          DW        = 16,
  parameter int          IW        = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  mode_e         mode,
  input  logic [IW-1:0] idx,
  input  logic          step,
  input  logic          load,
  output logic [DW-1:0] pattern
);

  localparam logic [31:0] DW_U = DW;

  logic [15:0] lfsr_r;
  logic [31:0] idx32_s;

  // LFSR reseeds at the start of every burst and advances once per consumed beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else if (load) begin
      lfsr_r <= LFSR_SEED;
    end else if (step) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // Pattern word selected by mode from beat index and LFSR state
  always_comb begin
    idx32_s = 32'(idx);
    pattern = {DW{1'b0}};
    case (mode)
      MODE_COUNT: pattern = DW'(idx);
      MODE_WALK:  pattern = {{(DW-1){1'b0}}, 1'b1} << (idx32_s % DW_U);
      MODE_LFSR:  pattern = DW'(lfsr_r);
      MODE_ALT:   pattern = idx[0] ? {(DW/8){8'hAA}} : {(DW/8){8'h55}};
      default:    pattern = {DW{1'b0}};
    endcase
  end

endmodule

// File: rtl/sdram_bist_ctrl.sv
// SDRAM test-traffic controller: writes a pattern burst, reads it back and checks it,
// and streams the returned words to the UART TX as bytes, MSB byte first.
module sdram_bist_ctrl
  import sdram_bist_pkg::*;
#(
  parameter int          DW         = 16,
  parameter int          AW         = 13,
  parameter int          BURST_LEN  = 512,
  parameter int          FIFO_DEPTH = 512,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_wr,
  input  logic          start_rd,
  input  logic          bank_inc,
  input  logic          page_inc,
  input  logic [1:0]    mode,
  output logic          wr_req,
  input  logic          wr_ack,
  output logic          rd_req,
  input  logic          rd_ack,
  output logic [1:0]    bank,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] sd_data,
  input  logic          sd_data_vld,
  input  logic          tx_rdy,
  output logic [7:0]    tx_data,
  output logic          tx_vld,
  output logic          busy,
  output logic          done,
  output logic [15:0]   err_cnt,
  output logic          ovf
);

  localparam int             IW       = $clog2(BURST_LEN + 1);
  localparam int             FAW      = $clog2(FIFO_DEPTH);
  localparam int             PW       = FAW + 1;
  localparam int             NB       = DW / 8;
  localparam int             CW       = $clog2(NB + 1) + 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(BURST_LEN - 1);
  localparam logic [CW-1:0]  NB_C     = CW'(NB);

  state_e        state_r, state_nx;
  mode_e         mode_r;
  logic [IW-1:0] idx_r;
  logic          last_s, beat_s;
  logic          wr_load_s, wr_step_s, chk_load_s, chk_step_s;
  logic [DW-1:0] wr_pat_s, chk_pat_s;
  logic          rd_vld_s, rd_start_s, chk_bad_s;

  logic [DW-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0] wp_r, rp_r;
  logic          empty_s, full_s, push_s, pop_s, emit_s;
  logic [DW-1:0] sh_r;
  logic [CW-1:0] ser_cnt_r;

  assign last_s     = (idx_r == LAST_IDX);
  assign busy       = (state_r != ST_IDLE);
  assign wdata      = (state_r == ST_WR_BURST) ? wr_pat_s : {DW{1'b0}};
  assign rd_vld_s   = (state_r == ST_RD_BURST) && sd_data_vld;
  assign rd_start_s = (state_r == ST_IDLE) && start_rd && !start_wr;
  assign chk_bad_s  = rd_vld_s && (sd_data != chk_pat_s);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state, handshake outputs and pattern-generator control
  always_comb begin
    state_nx   = state_r;
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    done       = 1'b0;
    beat_s     = 1'b0;
    wr_load_s  = 1'b0;
    wr_step_s  = 1'b0;
    chk_load_s = 1'b0;
    chk_step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_wr) begin
          state_nx = ST_WR_REQ;
        end else if (start_rd) begin
          state_nx = ST_RD_REQ;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        wr_req = 1'b1;
        if (wr_ack) begin
          wr_load_s = 1'b1;
          state_nx  = ST_WR_BURST;
        end else begin
          state_nx = ST_WR_REQ;
        end
      end
      ST_WR_BURST: begin
        beat_s    = 1'b1;
        wr_step_s = 1'b1;
        if (last_s) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_WR_BURST;
        end
      end
      ST_RD_REQ: begin
        rd_req = 1'b1;
        if (rd_ack) begin
          chk_load_s = 1'b1;
          state_nx   = ST_RD_BURST;
        end else begin
          state_nx = ST_RD_REQ;
        end
      end
      ST_RD_BURST: begin
        if (sd_data_vld) begin
          beat_s     = 1'b1;
          chk_step_s = 1'b1;
          if (last_s) begin
            done     = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_RD_BURST;
          end
        end else begin
          state_nx = ST_RD_BURST;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Beat index, latched mode, and bank/page selection (editable only while idle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r  <= {IW{1'b0}};
      mode_r <= MODE_COUNT;
      bank   <= 2'd0;
      addr   <= {AW{1'b0}};
    end else begin
      if (beat_s) begin
        idx_r <= last_s ? {IW{1'b0}} : idx_r + IW'(1'b1);
      end
      if (state_r == ST_IDLE) begin
        if (start_wr || start_rd) begin
          mode_r <= mode_e'(mode);
        end
        if (bank_inc) begin
          bank <= bank + 2'd1;
        end
        if (page_inc) begin
          addr <= addr + AW'(1'b1);
        end
      end
    end
  end

  sdram_bist_patgen #(.DW(DW), .IW(IW), .LFSR_SEED(LFSR_SEED)) u_wr_gen (
    .clk(clk), .rst_n(rst_n), .mode(mode_r), .idx(idx_r),
    .step(wr_step_s), .load(wr_load_s), .pattern(wr_pat_s)
  );

  sdram_bist_patgen #(.DW(DW), .IW(IW), .LFSR_SEED(LFSR_SEED)) u_chk_gen (
    .clk(clk), .rst_n(rst_n), .mode(mode_r), .idx(idx_r),
    .step(chk_step_s), .load(chk_load_s), .pattern(chk_pat_s)
  );

  // Mismatch counter and overflow flag, both cleared when a read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'h0000;
      ovf     <= 1'b0;
    end else if (rd_start_s) begin
      err_cnt <= 16'h0000;
      ovf     <= 1'b0;
    end else begin
      if (chk_bad_s && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'h0001;
      end
      if (rd_vld_s && full_s) begin
        ovf <= 1'b1;
      end
    end
  end

  assign empty_s = (wp_r == rp_r);
  assign full_s  = (wp_r[FAW] != rp_r[FAW]) && (wp_r[FAW-1:0] == rp_r[FAW-1:0]);
  assign push_s  = rd_vld_s && !full_s;
  assign emit_s  = (ser_cnt_r != {CW{1'b0}}) && tx_rdy;
  // Reload on the last byte so a steady stream has no idle gap between words
  assign pop_s   = !empty_s && tx_rdy && (ser_cnt_r <= CW'(1'b1));

  // Read-data buffer storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wp_r[FAW-1:0]] <= sd_data;
    end
  end

  // Buffer pointers and byte serializer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r      <= {PW{1'b0}};
      rp_r      <= {PW{1'b0}};
      sh_r      <= {DW{1'b0}};
      ser_cnt_r <= {CW{1'b0}};
      tx_vld    <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      if (push_s) begin
        wp_r <= wp_r + PW'(1'b1);
      end
      if (pop_s) begin
        rp_r      <= rp_r + PW'(1'b1);
        sh_r      <= mem_r[rp_r[FAW-1:0]];
        ser_cnt_r <= NB_C;
      end else if (emit_s) begin
        sh_r      <= sh_r << 8;
        ser_cnt_r <= ser_cnt_r - CW'(1'b1);
      end
      tx_vld  <= emit_s;
      tx_data <= emit_s ? sh_r[DW-1 -: 8] : 8'h00;
    end
  end

endmodule

// File: tb/tb_sdram_bist_ctrl.sv
// Randomized self-checking bench for sdram_bist_ctrl against a pattern/byte-stream reference model.
module tb_sdram_bist_ctrl;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int BL = 512;
  localparam int FD = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_wr = 1'b0, start_rd = 1'b0, bank_inc = 1'b0, page_inc = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          wr_req, rd_req, wr_ack = 1'b0, rd_ack = 1'b0;
  logic [1:0]    bank;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] sd_data = 16'h0000;
  logic          sd_data_vld = 1'b0;
  logic          tx_rdy = 1'b1;
  logic [7:0]    tx_data;
  logic          tx_vld, busy, done, ovf;
  logic [15:0]   err_cnt;

  sdram_bist_ctrl #(.DW(DW), .AW(AW), .BURST_LEN(BL), .FIFO_DEPTH(FD), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start_wr(start_wr), .start_rd(start_rd),
    .bank_inc(bank_inc), .page_inc(page_inc), .mode(mode),
    .wr_req(wr_req), .wr_ack(wr_ack), .rd_req(rd_req), .rd_ack(rd_ack),
    .bank(bank), .addr(addr), .wdata(wdata), .sd_data(sd_data), .sd_data_vld(sd_data_vld),
    .tx_rdy(tx_rdy), .tx_data(tx_data), .tx_vld(tx_vld), .busy(busy), .done(done),
    .err_cnt(err_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int          vec_cnt = 0;
  int          miscmp  = 0;
  logic [15:0] lfsr_seq [BL];
  logic [15:0] wd [BL];
  logic [7:0]  rx_q [$];
  logic [7:0]  exp_q [$];
  int          held = 0;
  logic [1:0]  m_bank = 2'd0;
  logic [12:0] m_addr = 13'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_pat(input int m, input int i);
    case (m)
      0:       return 16'(i);
      1:       return 16'h0001 << (i % 16);
      2:       return lfsr_seq[i];
      default: return ((i % 2) == 0) ? 16'h5555 : 16'hAAAA;
    endcase
  endfunction

  // Every byte the DUT presents is collected for later comparison
  always @(negedge clk) begin
    if (rst_n && tx_vld) rx_q.push_back(tx_data);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int m, input int d, input bit both);
    int n;
    mode = 2'(m);
    start_wr = 1'b1;
    start_rd = both;
    @(negedge clk);
    cyc();
    start_wr = 1'b0;
    start_rd = 1'b0;
    n = 0;
    do begin
      n++;
      wr_ack = (n == d);
      @(negedge clk);
      chk("wr_req_hold", 32'(wr_req), 32'd1);
      chk("rd_req_idle", 32'(rd_req), 32'd0);
      cyc();
      wr_ack = 1'b0;
    end while (n < d);
    for (int i = 0; i < BL; i++) begin
      if (i == 5) mode = 2'($urandom);
      bank_inc = (i == 10);
      page_inc = (i == 10);
      start_rd = (i == 10);
      @(negedge clk);
      chk("wdata", 32'(wdata), 32'(ref_pat(m, i)));
      chk("wr_done", 32'(done), 32'(i == BL - 1));
      if (i == 0) begin
        chk("wr_req_off", 32'(wr_req), 32'd0);
        chk("wr_busy", 32'(busy), 32'd1);
      end
      wd[i] = wdata;
      cyc();
    end
    @(negedge clk);
    chk("wr_end_busy", 32'(busy), 32'd0);
    chk("wr_end_done", 32'(done), 32'd0);
    chk("wr_end_wdata", 32'(wdata), 32'd0);
    chk("bank_hold", 32'(bank), 32'(m_bank));
    chk("addr_hold", 32'(addr), 32'(m_addr));
    cyc();
  endtask

  task automatic do_read(input int m, input int err_pct, input int vld_pct, input bit rdy,
                         input int force_i, input bit echo);
    int n, d, i, guard, exp_err;
    bit exp_ovf;
    logic [15:0] v;
    tx_rdy = rdy;
    mode = 2'(m);
    start_rd = 1'b1;
    @(negedge clk);
    cyc();
    start_rd = 1'b0;
    d = int'($urandom_range(4, 1));
    n = 0;
    do begin
      n++;
      rd_ack = (n == d);
      @(negedge clk);
      chk("rd_req_hold", 32'(rd_req), 32'd1);
      if (n == 1) begin
        chk("err_clr", 32'(err_cnt), 32'd0);
        chk("ovf_clr", 32'(ovf), 32'd0);
      end
      cyc();
      rd_ack = 1'b0;
    end while (n < d);
    exp_err = 0;
    exp_ovf = 1'b0;
    i = 0;
    guard = 0;
    while (i < BL && guard < 20 * BL) begin
      guard++;
      mode = 2'($urandom);
      if (int'($urandom_range(99, 0)) < vld_pct) begin
        v = echo ? wd[i] : ref_pat(m, i);
        if (i == force_i) v = 16'hDEAD;
        else if (int'($urandom_range(99, 0)) < err_pct) v = v ^ 16'($urandom_range(65535, 1));
        if (v != ref_pat(m, i)) exp_err++;
        if (rdy || held < FD) begin
          exp_q.push_back(v[15:8]);
          exp_q.push_back(v[7:0]);
          held++;
        end else begin
          exp_ovf = 1'b1;
        end
        sd_data_vld = 1'b1;
        sd_data = v;
        @(negedge clk);
        chk("rd_done", 32'(done), 32'(i == BL - 1));
        cyc();
        i++;
      end else begin
        sd_data_vld = 1'b0;
        sd_data = 16'($urandom);
        @(negedge clk);
        cyc();
      end
    end
    sd_data_vld = 1'b0;
    if (i < BL) chk("rd_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("rd_end_busy", 32'(busy), 32'd0);
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    cyc();
  endtask

  task automatic drain();
    int guard;
    tx_rdy = 1'b1;
    guard = 0;
    while (rx_q.size() < exp_q.size() && guard < 6000) begin
      cyc();
      guard++;
    end
    repeat (8) cyc();
    chk("byte_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++)
      chk($sformatf("byte%0d", k), 32'(rx_q[k]), 32'(exp_q[k]));
    rx_q.delete();
    exp_q.delete();
    held = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_req"}, 32'(wr_req), 32'd0);
    chk({tag, "_rd_req"}, 32'(rd_req), 32'd0);
    chk({tag, "_bank"}, 32'(bank), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_wdata"}, 32'(wdata), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_tx_vld"}, 32'(tx_vld), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    logic [15:0] s;
    int m, guard;
    s = 16'hACE1;
    for (int i = 0; i < BL; i++) begin
      lfsr_seq[i] = s;
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    end

    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    cyc();
    rst_n = 1'b1;
    cyc();

    // count pattern write with a 3-cycle grant, then read back clean and with one bad beat
    do_write(0, 3, 1'b0);
    do_read(0, 0, 100, 1'b1, -1, 1'b0);
    drain();
    do_read(0, 0, 100, 1'b1, 6, 1'b0);
    guard = 0;
    while (rx_q.size() < 14 && guard < 200) begin
      cyc();
      guard++;
    end
    if (rx_q.size() >= 14) begin
      chk("dead_hi", 32'(rx_q[12]), 32'h0000_00DE);
      chk("dead_lo", 32'(rx_q[13]), 32'h0000_00AD);
    end else begin
      chk("dead_bytes", 32'(rx_q.size()), 32'd14);
    end
    drain();

    // simultaneous starts: write wins
    do_write(1, 2, 1'b1);

    // LFSR write echoed back as read data
    do_write(2, int'($urandom_range(5, 1)), 1'b0);
    chk("lfsr_first", 32'(wd[0]), 32'h0000_ACE1);
    do_read(2, 0, 70, 1'b1, -1, 1'b1);
    drain();

    for (int r = 0; r < 4; r++) begin
      m = int'($urandom_range(3, 0));
      do_write(m, int'($urandom_range(6, 1)), 1'($urandom_range(1, 0)));
      do_read(m, 10, int'($urandom_range(100, 40)), 1'b1, -1, 1'b0);
      drain();
    end

    // TX stalled: first burst fills the buffer, second overflows it
    m = int'($urandom_range(3, 0));
    do_read(m, 5, 100, 1'b0, -1, 1'b0);
    do_read(m, 50, 100, 1'b0, -1, 1'b0);
    repeat (20) cyc();
    chk("stalled_bytes", 32'(rx_q.size()), 32'd0);
    drain();

    // bank/page selection in IDLE
    for (int k = 0; k < 5; k++) begin
      bank_inc = 1'b1;
      page_inc = (k < 3);
      cyc();
      bank_inc = 1'b0;
      page_inc = 1'b0;
      cyc();
    end
    m_bank = m_bank + 2'd1;
    m_addr = m_addr + 13'd3;
    @(negedge clk);
    chk("bank_inc5", 32'(bank), 32'(m_bank));
    chk("page_inc3", 32'(addr), 32'(m_addr));
    cyc();

    // asynchronous reset in the middle of a write burst
    mode = 2'd3;
    start_wr = 1'b1;
    cyc();
    start_wr = 1'b0;
    wr_ack = 1'b1;
    cyc();
    wr_ack = 1'b0;
    repeat (100) cyc();
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    m_bank = 2'd0;
    m_addr = 13'd0;
    cyc();
    rst_n = 1'b1;
    cyc();
    do_write(3, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
